// File: rtl/mul_wb_pkg.sv
// Shared types and width helpers for the multiplier writeback queue.
// Machine-width macros fall back to defaults when machine.vh is not in the build.
`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 5
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 6
`endif
`ifndef MUL_LAT
`define MUL_LAT 3
`endif

package mul_wb_pkg;

  localparam int DATA_W = `M_WIDTH;
  localparam int ROB_W  = `LG_ROB_ENTRIES;
  localparam int PRF_W  = `LG_PRF_ENTRIES;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob_ptr;
    logic              prf_val;
    logic [PRF_W-1:0]  prf_ptr;
  } mul_wb_entry_t;

  localparam int ENTRY_W = $bits(mul_wb_entry_t);

  // Holds every op that can be in the pipe plus the buffered ones.
  function automatic int inflight_width(input int depth, input int lat);
    return $clog2(depth + lat + 2);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Parametric synchronous FIFO: combinational head read, register storage
// cleared on reset, pointer/count clear without touching storage.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A push into a full FIFO is accepted only when the head leaves this cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_reg[head_reg];
  assign count    = count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + PTR_W'(1);
      if (do_pop)  head_reg <= head_reg + PTR_W'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
      else if (!do_push && do_pop) count_reg <= count_reg - CNT_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_reg[gi] <= '0;
        end else if (do_push && tail_reg == PTR_W'(gi)) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mul_wb_queue.sv
// Buffers fixed-latency multiplier completions and drains them to the shared
// writeback port; issue credits keep the non-stallable pipe from overflowing.
`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 5
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 6
`endif
`ifndef MUL_LAT
`define MUL_LAT 3
`endif

module mul_wb_queue
  import mul_wb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = `MUL_LAT,
  parameter int W       = `M_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       mul_go,
  output logic                       mul_issue_ok,
  input  logic                       mul_complete,
  input  logic [W-1:0]               mul_y,
  input  logic [`LG_ROB_ENTRIES-1:0] mul_rob_ptr,
  input  logic                       mul_prf_val,
  input  logic [`LG_PRF_ENTRIES-1:0] mul_prf_ptr,
  output logic                       wb_valid,
  input  logic                       wb_ack,
  output logic [W-1:0]               wb_data,
  output logic [`LG_ROB_ENTRIES-1:0] wb_rob_ptr,
  output logic                       wb_prf_val,
  output logic [`LG_PRF_ENTRIES-1:0] wb_prf_ptr,
  output logic                       err_overflow
);

  localparam int IF_W  = inflight_width(DEPTH, MUL_LAT);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = ((IF_W > CNT_W) ? IF_W : CNT_W) + 1;

  logic [IF_W-1:0]  inflight_reg;
  logic [IF_W-1:0]  inflight_next;
  logic [IF_W-1:0]  drop_cnt_reg;
  logic [IF_W-1:0]  drop_cnt_next;
  logic             err_reg;
  logic             err_next;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push_req;
  logic             pop_req;
  logic             overflow;
  mul_wb_entry_t    push_entry;
  mul_wb_entry_t    head_entry;

  assign inflight_next = inflight_reg + IF_W'(mul_go) - IF_W'(mul_complete);

  // Credit depends on registered state only, so a go always finds a slot
  // when its result lands MUL_LAT+1 cycles later.
  assign mul_issue_ok = (SUM_W'(count) + SUM_W'(inflight_reg)) < SUM_W'(DEPTH);

  assign push_req = mul_complete & (drop_cnt_reg == '0) & ~flush;
  assign wb_valid = ~empty;
  assign pop_req  = wb_valid & wb_ack & ~flush;
  assign overflow = push_req & full & ~pop_req;
  assign err_next = err_reg | overflow | (mul_go & ~mul_issue_ok);

  // Every op still in the pipe after a flush predates it, and completions
  // return in issue order, so counting them down discards exactly those.
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (flush) begin
      drop_cnt_next = inflight_next;
    end else if (mul_complete && drop_cnt_reg != '0) begin
      drop_cnt_next = drop_cnt_reg - IF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      inflight_reg <= inflight_next;
      drop_cnt_reg <= drop_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    push_entry         = '0;
    push_entry.data    = DATA_W'(mul_y);
    push_entry.rob_ptr = mul_rob_ptr;
    push_entry.prf_val = mul_prf_val;
    push_entry.prf_ptr = mul_prf_ptr;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (pop_req),
    .pop_data  (head_entry),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign wb_data      = W'(head_entry.data);
  assign wb_rob_ptr   = head_entry.rob_ptr;
  assign wb_prf_val   = head_entry.prf_val;
  assign wb_prf_ptr   = head_entry.prf_ptr;
  assign err_overflow = err_reg;

endmodule

// File: doc/mul_wb_queue.md
Name: mul_wb_queue

Overview:
- Receive-side companion to the pipelined multiplier.
- Accepts every fixed-latency multiply completion (result, ROB pointer, PRF pointer), buffers it in a small FIFO, and drains it to the shared writeback/ROB-completion port through a valid/ack handshake.
- Returns an issue credit to the scheduler so the non-stallable multiplier pipe can never overflow the buffer.
- Discards results for in-flight ops on a pipeline flush.

Parameters:
- DEPTH, 4, FIFO entries; power of two; must be >= 2.
- MUL_LAT, `MUL_LAT, multiplier stage index; go-to-complete latency is MUL_LAT+1 cycles.
- W, `M_WIDTH, result width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; all buffered and in-flight results are discarded
- mul_go  in  1  an op was issued to the multiplier this cycle
- mul_issue_ok  out  1  scheduler may assert mul_go this cycle
- mul_complete  in  1  multiplier result valid
- mul_y  in  W  multiplier result
- mul_rob_ptr  in  `LG_ROB_ENTRIES  ROB pointer of the result
- mul_prf_val  in  1  result has a destination register
- mul_prf_ptr  in  `LG_PRF_ENTRIES  destination PRF pointer
- wb_valid  out  1  head entry presented
- wb_ack  in  1  writeback arbiter accepts the head
- wb_data  out  W  head result
- wb_rob_ptr  out  `LG_ROB_ENTRIES  head ROB pointer
- wb_prf_val  out  1  head has a destination register
- wb_prf_ptr  out  `LG_PRF_ENTRIES  head PRF pointer
- err_overflow  out  1  sticky protocol-error flag

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- Reset state:
  - count, head, tail, inflight and drop_cnt are all 0.
  - wb_valid=0, err_overflow=0, mul_issue_ok=1.
  - wb_data, wb_rob_ptr, wb_prf_val and wb_prf_ptr read 0 (storage is cleared).
- inflight counter:
  - Next value = inflight + mul_go - mul_complete.
  - Width is clog2(DEPTH+MUL_LAT+2).
  - Counts every issued op, including ops marked for drop.
- Credit:
  - mul_issue_ok = (count + inflight) < DEPTH.
  - Combinational from registers only; no dependence on wb_ack.
  - Consequence: a go in cycle t is always guaranteed a slot at completion in cycle t+MUL_LAT+1.
- Push: occurs when mul_complete=1, drop_cnt=0 and flush=0. The entry is written at tail and tail is incremented modulo DEPTH.
- Pop:
  - Occurs when wb_valid & wb_ack & !flush; head is incremented modulo DEPTH.
  - wb_* outputs come combinationally from the head entry; wb_valid = (count != 0).
  - There is no same-cycle bypass: a pushed entry is first visible on the next cycle.
- Simultaneous push and pop: count is unchanged; legal even when count==DEPTH.
- Push with count==DEPTH and no pop:
  - The entry is dropped and err_overflow is set; it is sticky until reset.
  - Unreachable while the credit rule is obeyed.
- mul_go while mul_issue_ok=0: err_overflow is set. The op is still counted in inflight.
- Flush cycle:
  - count, head and tail go to 0; wb_valid is low the next cycle.
  - drop_cnt <= inflight + mul_go - mul_complete; a completion arriving in the flush cycle is itself discarded.
- After flush:
  - While drop_cnt>0, each mul_complete is discarded and drop_cnt decrements.
  - Results flow normally once drop_cnt reaches 0.
  - Because completions are in issue order, the dropped ones are exactly the pre-flush ops.
- Flush and reset together: reset wins.
- mul_prf_val=0 entries are still queued and popped, because the ROB needs the completion; wb_prf_val=0 tells the PRF write to be suppressed.

Decomposition:
- Package mul_wb_pkg holds:
  - the typedef mul_wb_entry_t {data W, rob_ptr, prf_val, prf_ptr};
  - the localparams for pointer and counter widths.
- Widths come from machine.vh macros (`M_WIDTH, `LG_ROB_ENTRIES, `LG_PRF_ENTRIES, `MUL_LAT).
- Sub-module: sync_fifo (parametric width/depth, push/pop/clear, count, full/empty). The credit and drop logic stay in mul_wb_queue.

Test Plan:
- Reset, then a single go with rob=5, prf=17, y=0x1234 completing MUL_LAT+1 cycles later, wb_ack held 1:
  - wb_valid rises the cycle after complete with wb_rob_ptr=5, wb_prf_ptr=17, wb_data=0x1234;
  - count returns to 0.
- Issue go every cycle while mul_issue_ok allows, with wb_ack=0, DEPTH=4:
  - exactly 4 ops are issued, then mul_issue_ok=0;
  - 4 entries are buffered, err_overflow stays 0.
- From full, assert wb_ack=1 and a new complete in the same cycle:
  - count stays 4, FIFO order is preserved across the tail wrap (e.g. rob 0,1,2,3,4 drained in order).
- Issue 3 ops, flush 1 cycle after the 2nd go, while the 3rd go arrives in the flush cycle:
  - drop_cnt=3, all 3 completions are discarded, wb_valid stays 0;
  - a post-flush op (rob=9) is written back normally.
- Force mul_go with mul_issue_ok=0:
  - err_overflow=1 next cycle and stays 1 until reset;
  - reset clears it along with count/inflight.
- Complete with mul_prf_val=0, rob=7: entry is presented with wb_prf_val=0, wb_rob_ptr=7, and popped on ack.
